// File: rtl/audio_sfx_scheduler.sv
// audio_sfx_scheduler: Wishbone-fed SFX request queue that owns the player's clip select,
// with rewind gaps, urgent preemption and theme fallback. Optional watchdog: AUDIO_SCHED_TIMEOUT_EN.
//   state | meaning
//   IDLE  | nothing to play, play_sel = 0
//   THEME | background theme playing, play_sel = THEME_ID
//   GAP   | play_sel = 0 for GAP_CYCLES so the player rewinds
//   SFX   | popped SFX id playing until play_done
module audio_sfx_scheduler #(
  parameter int          QUEUE_DEPTH    = 4,
  parameter int          GAP_CYCLES     = 4,
  parameter int          THEME_ID       = 1,
  parameter int          MAX_ID         = 10,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [3:0]  play_sel,
  input  logic        play_done,
  output logic        irq_o
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, THEME = 2'd1, GAP = 2'd2, SFX = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;
  logic          theme_en_q, theme_en_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          timeout_q;
  logic [3:0]    mem_q [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          urg_q, urg_d;
  logic [3:0]    urg_id_q, urg_id_d;
  logic [3:0]    cur_id_q, cur_id_d;
  logic [GW-1:0] gap_cnt_q;

  logic       bus_req, wr_en, wr_ctrl, wr_req, wr_clr;
  logic [3:0] req_id, pend_id;
  logic       req_urg, req_ok, urg_now, push_req, flush_now, clr_fifo;
  logic       fifo_full, fifo_avail, urg_pend, work_avail;
  logic       pop, take_urg, sfx_done, push_ok, wd_expire;
  logic       unused_bits;

  assign bus_req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en     = bus_req & wb_we_i;
  assign wr_ctrl   = wr_en && (wb_adr_i[3:2] == 2'd0);
  assign wr_req    = wr_en && (wb_adr_i[3:2] == 2'd1);
  assign wr_clr    = wr_en && (wb_adr_i[3:2] == 2'd3);
  assign req_id    = wb_dat_i[3:0];
  assign req_urg   = wb_dat_i[8];
  assign req_ok    = wr_req && (req_id >= 4'd2) && ({28'd0, req_id} <= 32'(MAX_ID));
  assign urg_now   = req_ok & req_urg;
  assign push_req  = req_ok & ~req_urg;
  assign flush_now = wr_ctrl & wb_dat_i[1];
  // An urgent request replaces the whole queue; its id waits in a side slot so count reads 0.
  assign clr_fifo  = flush_now | urg_now;

  assign fifo_full  = (cnt_q == CW'(QUEUE_DEPTH));
  assign fifo_avail = (cnt_q != '0) && !clr_fifo;
  assign urg_pend   = (urg_q & ~flush_now) | urg_now;
  assign pend_id    = urg_now ? req_id : urg_id_q;
  assign work_avail = urg_pend | fifo_avail;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    push_ok  = 1'b0;
    if (clr_fifo) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      push_ok = push_req & (~fifo_full | pop);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push_ok) cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    pop      = 1'b0;
    take_urg = 1'b0;
    sfx_done = 1'b0;
    case (state_q)
      IDLE: if (work_avail || theme_en_q) state_d = GAP;
      GAP: begin
        if (gap_cnt_q == '0) begin
          if (urg_pend) begin
            state_d  = SFX;
            take_urg = 1'b1;
            cur_id_d = pend_id;
          end else if (fifo_avail) begin
            state_d  = SFX;
            pop      = 1'b1;
            cur_id_d = mem_q[rd_ptr_q];
          end else if (theme_en_q) begin
            state_d = THEME;
          end else begin
            state_d = IDLE;
          end
        end
      end
      THEME: if (work_avail || !theme_en_q) state_d = GAP;
      SFX: begin
        if (urg_now) begin
          state_d = GAP;
        end else if (play_done || wd_expire) begin
          state_d  = GAP;
          sfx_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    theme_en_d = theme_en_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    urg_d      = urg_q;
    urg_id_d   = urg_id_q;
    if (wr_ctrl) theme_en_d = wb_dat_i[0];
    if (flush_now) urg_d = 1'b0;
    if (urg_now) begin
      urg_d    = 1'b1;
      urg_id_d = req_id;
    end
    if (take_urg) urg_d = 1'b0;
    if (wr_clr && wb_dat_i[16]) ovf_d = 1'b0;
    if (wr_clr && wb_dat_i[17]) done_d = 1'b0;
    if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    if (sfx_done && (cnt_d == '0) && !urg_d) done_d = 1'b1;
  end

  always_comb begin
    dat_d = '0;
    if (bus_req && !wb_we_i) begin
      case (wb_adr_i[3:2])
        2'd0:    dat_d = {31'd0, theme_en_q};
        2'd2:    dat_d = {13'd0, timeout_q, done_q, ovf_q, 5'd0, 1'b0, state_q, 3'd0, 5'(cnt_q)};
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      state_q    <= IDLE;
      theme_en_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      urg_q      <= 1'b0;
      urg_id_q   <= '0;
      cur_id_q   <= '0;
      gap_cnt_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ack_q      <= bus_req;
      dat_q      <= dat_d;
      state_q    <= state_d;
      theme_en_q <= theme_en_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      urg_q      <= urg_d;
      urg_id_q   <= urg_id_d;
      cur_id_q   <= cur_id_d;
      if (push_ok) mem_q[wr_ptr_q] <= req_id;
      if (state_q != GAP)       gap_cnt_q <= GW'(GAP_CYCLES - 1);
      else if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GW'(1);
    end
  end

`ifdef AUDIO_SCHED_TIMEOUT_EN
  logic [23:0] wd_cnt_q;
  logic        timeout_d;

  assign wd_expire = (state_q == SFX) && (wd_cnt_q == '0);

  always_comb begin
    timeout_d = timeout_q;
    if (wr_clr && wb_dat_i[18]) timeout_d = 1'b0;
    if (wd_expire && !urg_now) timeout_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != SFX)      wd_cnt_q <= TIMEOUT_CYCLES - 24'd1;
      else if (wd_cnt_q != '0) wd_cnt_q <= wd_cnt_q - 24'd1;
      timeout_q <= timeout_d;
    end
  end

  assign irq_o       = done_q | ovf_q | timeout_q;
  assign unused_bits = ^{wb_adr_i[7:4], wb_adr_i[1:0], wb_dat_i[31:19], wb_dat_i[15:9], wb_dat_i[7:4]};
`else
  assign wd_expire   = 1'b0;
  assign timeout_q   = 1'b0;
  assign irq_o       = done_q | ovf_q;
  assign unused_bits = ^{wb_adr_i[7:4], wb_adr_i[1:0], wb_dat_i[31:18], wb_dat_i[15:9],
                         wb_dat_i[7:4], TIMEOUT_CYCLES};
`endif

  always_comb begin
    play_sel = 4'd0;
    if (state_q == THEME)    play_sel = 4'(THEME_ID);
    else if (state_q == SFX) play_sel = cur_id_q;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Scoreboard bench for audio_sfx_scheduler: bus reads and play_sel transitions are queued
// as expectations by the stimulus and checked by independent monitors.
module tb_audio_sfx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic [3:0]  sel;
  logic        done = 1'b0;
  logic        irq;

  int tests = 0;
  int fails = 0;

  typedef struct { logic chk; logic [31:0] exp; string nm; } rd_t;
  typedef struct { logic [3:0] val; int run; } ps_t;

  rd_t rd_q[$];
  ps_t ps_q[$];

  always #5 clk = ~clk;

  audio_sfx_scheduler #(.TIMEOUT_CYCLES(24'd100)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .play_sel (sel),
    .play_done(done),
    .irq_o    (irq)
  );

  // Bus monitor: every ack consumes one queued expectation.
  logic ack_prev = 1'b0;
  rd_t  r_mon;
  always @(negedge clk) begin
    if (ack) begin
      if (ack_prev) begin
        tests++; fails++;
        $display("FAIL ack_back_to_back: ack high on two consecutive cycles");
      end
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL ack_unexpected: ack with no transfer outstanding");
      end else begin
        r_mon = rd_q.pop_front();
        if (r_mon.chk) begin
          tests++;
          if (rdat !== r_mon.exp) begin
            fails++;
            $display("FAIL %s: read 0x%08h expected 0x%08h", r_mon.nm, rdat, r_mon.exp);
          end
        end
      end
    end
    ack_prev = ack;
  end

  // play_sel monitor: each change consumes one expectation; run>0 also checks the
  // length of the segment that just ended (the rewind gap).
  logic [3:0] last_sel = 4'd0;
  int         run = 0;
  ps_t        p_mon;
  always @(negedge clk) begin
    if (sel !== last_sel) begin
      tests++;
      if (ps_q.size() == 0) begin
        fails++;
        $display("FAIL play_sel_unexpected: changed to %0d with nothing expected", sel);
      end else begin
        p_mon = ps_q.pop_front();
        if (sel !== p_mon.val || (p_mon.run != 0 && run != p_mon.run)) begin
          fails++;
          $display("FAIL play_sel_seq: got sel=%0d after run %0d, expected sel=%0d after run %0d",
                   sel, run, p_mon.val, p_mon.run);
        end
      end
      last_sel = sel;
      run = 1;
    end else begin
      run++;
    end
  end

  task automatic exp_sel(input logic [3:0] v, input int r);
    ps_t e;
    e.val = v;
    e.run = r;
    ps_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic chk, input logic [31:0] exp, input string nm);
    rd_t e;
    int  n;
    e.chk = chk;
    e.exp = exp;
    e.nm  = nm;
    rd_q.push_back(e);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      tests++; fails++;
      $display("FAIL wb_ack_timeout %s: no ack after %0d cycles", nm, n);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    wb_xfer(1'b0, a, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic wait_sel(input logic [3:0] v, input string nm);
    int n;
    n = 0;
    while (sel !== v && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 32'(sel), 32'(v));
  endtask

  task automatic pulse_done();
    @(negedge clk) done = 1'b1;
    @(negedge clk) done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_play_sel", 32'(sel), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    rd(8'h08, 32'h0, "reset_status");
    rd(8'h00, 32'h0, "reset_ctrl");

    // theme enable: one IDLE cycle, then GAP_CYCLES of zero, then theme
    exp_sel(4'd1, 0);
    wr(8'h00, 32'h1);
    n = 0;
    while (sel !== 4'd1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("theme_latency", 32'(n), 32'd5);
    rd(8'h08, 32'h0000_0100, "status_theme");

    // two queued SFX in order, then back to theme with done irq
    exp_sel(4'd0, 0); exp_sel(4'd5, 4);
    exp_sel(4'd0, 0); exp_sel(4'd8, 4);
    exp_sel(4'd0, 0); exp_sel(4'd1, 4);
    wr(8'h04, 32'd5);
    wr(8'h04, 32'd8);
    wait_sel(4'd5, "wait_sfx5");
    repeat (3) @(negedge clk);
    pulse_done();
    wait_sel(4'd8, "wait_sfx8");
    repeat (3) @(negedge clk);
    pulse_done();
    wait_sel(4'd1, "wait_theme_back");
    @(negedge clk);
    check("irq_after_drain", 32'(irq), 32'd1);
    rd(8'h08, 32'h0002_0100, "status_done");
    wr(8'h0C, 32'h0002_0000);
    rd(8'h08, 32'h0000_0100, "status_done_clr");
    check("irq_done_clr", 32'(irq), 32'd0);

    // theme off, overflow while SFX 3 holds
    exp_sel(4'd0, 0);
    wr(8'h00, 32'h0);
    exp_sel(4'd3, 0);
    wr(8'h04, 32'd3);
    wait_sel(4'd3, "wait_sfx3");
    for (int i = 0; i < 5; i++) wr(8'h04, 32'd3);
    rd(8'h08, 32'h0001_0304, "status_overflow");
    check("irq_overflow", 32'(irq), 32'd1);
    wr(8'h0C, 32'h0001_0000);
    rd(8'h08, 32'h0000_0304, "status_ovf_clr");
    wr(8'h00, 32'h2);
    rd(8'h08, 32'h0000_0300, "status_flush");
    exp_sel(4'd0, 0);
    pulse_done();
    wait_sel(4'd0, "wait_gap_after_flush");
    repeat (6) @(negedge clk);
    rd(8'h08, 32'h0002_0000, "status_idle_done");
    check("irq_idle_done", 32'(irq), 32'd1);
    wr(8'h0C, 32'h0002_0000);
    check("irq_idle_clr", 32'(irq), 32'd0);

    // urgent preemption of SFX 6
    exp_sel(4'd6, 0);
    wr(8'h04, 32'd6);
    wait_sel(4'd6, "wait_sfx6");
    exp_sel(4'd0, 0); exp_sel(4'd9, 4);
    wr(8'h04, 32'h109);
    check("urgent_sel_zero", 32'(sel), 32'd0);
    rd(8'h08, 32'h0000_0200, "status_urgent");
    wait_sel(4'd9, "wait_sfx9");

    // out-of-range ids are dropped silently
    wr(8'h04, 32'd0);
    wr(8'h04, 32'd1);
    wr(8'h04, 32'd11);
    rd(8'h08, 32'h0000_0300, "status_drops");
    check("irq_drops", 32'(irq), 32'd0);

`ifdef AUDIO_SCHED_TIMEOUT_EN
    exp_sel(4'd0, 0);
    wait_sel(4'd0, "wait_timeout_gap");
    repeat (8) @(negedge clk);
    rd(8'h08, 32'h0006_0000, "status_timeout");
    check("irq_timeout", 32'(irq), 32'd1);
    wr(8'h0C, 32'h0007_0000);
    rd(8'h08, 32'h0, "status_timeout_clr");
    exp_sel(4'd2, 0);
    wr(8'h04, 32'd2);
    wait_sel(4'd2, "wait_sfx2");
`endif

    // asynchronous reset in the middle of a clip
    exp_sel(4'd0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(8'h08, 32'h0, "status_after_reset");
    rd(8'h00, 32'h0, "ctrl_after_reset");

    repeat (4) @(negedge clk);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("sel_queue_drained", 32'(ps_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
